// File: rtl/mul_16bit_seq_pkg.sv
// Shared constants and state encoding for the sequential multiplier and the
// adder-based blocks that sit around sum_16bit.
package mul_16bit_seq_pkg;

    localparam int ADD_W  = 16;
    localparam int PROD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_16bit_seq_sum_16bit.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a second lookahead level
// across the groups, so the group carries never ripple.
module sum_16bit (
    input  logic [15:0] nr1,
    input  logic [15:0] nr2,
    input  logic        carry_in,
    output logic [15:0] sum,
    output logic        carry_out
);

    logic [15:0] g_s;
    logic [15:0] p_s;
    logic [3:0]  grp_g_s;
    logic [3:0]  grp_p_s;
    logic [4:0]  grp_c_s;
    logic [16:0] bit_c_s;

    always_comb begin
        g_s     = nr1 & nr2;
        p_s     = nr1 ^ nr2;
        grp_g_s = 4'd0;
        grp_p_s = 4'd0;
        grp_c_s = 5'd0;
        bit_c_s = 17'd0;
        for (int k = 0; k < 4; k++) begin
            grp_g_s[k] = g_s[4*k+3]
                       | (p_s[4*k+3] & g_s[4*k+2])
                       | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                       | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
            grp_p_s[k] = &p_s[4*k +: 4];
        end
        // Second lookahead level: every group carry straight from carry_in.
        grp_c_s[0] = carry_in;
        grp_c_s[1] = grp_g_s[0] | (grp_p_s[0] & carry_in);
        grp_c_s[2] = grp_g_s[1] | (grp_p_s[1] & grp_g_s[0])
                   | (grp_p_s[1] & grp_p_s[0] & carry_in);
        grp_c_s[3] = grp_g_s[2] | (grp_p_s[2] & grp_g_s[1])
                   | (grp_p_s[2] & grp_p_s[1] & grp_g_s[0])
                   | (grp_p_s[2] & grp_p_s[1] & grp_p_s[0] & carry_in);
        grp_c_s[4] = grp_g_s[3] | (grp_p_s[3] & grp_g_s[2])
                   | (grp_p_s[3] & grp_p_s[2] & grp_g_s[1])
                   | (grp_p_s[3] & grp_p_s[2] & grp_p_s[1] & grp_g_s[0])
                   | (grp_p_s[3] & grp_p_s[2] & grp_p_s[1] & grp_p_s[0] & carry_in);
        for (int i = 0; i < 16; i++) begin
            if ((i % 4) == 0) begin
                bit_c_s[i] = grp_c_s[i/4];
            end else begin
                bit_c_s[i] = g_s[i-1] | (p_s[i-1] & bit_c_s[i-1]);
            end
        end
        bit_c_s[16] = grp_c_s[4];
        sum       = p_s ^ bit_c_s[15:0];
        carry_out = bit_c_s[16];
    end

endmodule

// File: rtl/mul_16bit_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier reusing one sum_16bit adder
// for sixteen steps; valid/ready handshakes on both operand and product sides.
module mul_16bit_seq
    import mul_16bit_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    if (WIDTH != ADD_W) begin : g_bad_width
        $error("mul_16bit_seq: WIDTH must equal the sum_16bit width");
    end
    if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt
        $error("mul_16bit_seq: CNT_W too small for WIDTH steps");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   addend_s;
    logic [WIDTH-1:0]   sum_s;
    logic               carry_s;

    assign addend_s = acc_lo_q[0] ? mcand_q : {WIDTH{1'b0}};

    sum_16bit u_sum (
        .nr1       (acc_hi_q),
        .nr2       (addend_s),
        .carry_in  (1'b0),
        .sum       (sum_s),
        .carry_out (carry_s)
    );

    // Next-state, datapath step and counter.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = mcand;
                    acc_lo_d = mplier;
                    acc_hi_d = {WIDTH{1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                {acc_hi_d, acc_lo_d} = {carry_s, sum_s, acc_lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= {WIDTH{1'b0}};
            acc_hi_q <= {WIDTH{1'b0}};
            acc_lo_q <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = {acc_hi_q, acc_lo_q};

endmodule

// File: tb/tb_mul_16bit_seq.sv
// Self-checking bench for mul_16bit_seq: directed vector table, reset abort,
// and a randomized valid/ready stream scored against plain a*b.
module tb_mul_16bit_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;

    int errors = 0;
    int checks = 0;

    mul_16bit_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mcand     (mcand),
        .mplier    (mplier),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
        int          hold;
        string       name;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        out_ready = 1'b0;
        check({v.name, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        mcand    = v.a;
        mplier   = v.b;
        tick();
        in_valid = 1'b0;
        mcand    = 16'($urandom);
        mplier   = 16'($urandom);
        check({v.name, " in_ready busy"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({v.name, " latency"}, 32'(lat), 32'd16);
        check({v.name, " product"}, product, v.exp);
        for (int i = 0; i < v.hold; i++) begin
            in_valid = 1'b1;
            mcand    = 16'($urandom);
            mplier   = 16'($urandom);
            tick();
            check({v.name, " held product"}, product, v.exp);
            check({v.name, " held out_valid"}, 32'(out_valid), 32'd1);
            check({v.name, " held in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({v.name, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({v.name, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    vec_t        vecs[5];
    logic [31:0] sb_q[$];
    int          sent;
    int          received;
    int          saw_valid;

    initial begin
        vecs[0] = '{a: 16'd3,     b: 16'd5,     exp: 32'h0000000F, hold: 0,  name: "3x5"};
        vecs[1] = '{a: 16'hFFFF,  b: 16'hFFFF,  exp: 32'hFFFE0001, hold: 0,  name: "ffffxffff"};
        vecs[2] = '{a: 16'h0000,  b: 16'hABCD,  exp: 32'h00000000, hold: 0,  name: "0xabcd"};
        vecs[3] = '{a: 16'h1234,  b: 16'h0000,  exp: 32'h00000000, hold: 0,  name: "1234x0"};
        vecs[4] = '{a: 16'h00FF,  b: 16'h0100,  exp: 32'h0000FF00, hold: 10, name: "backpressure"};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mcand = 16'd0; mplier = 16'd0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset product", product, 32'd0);

        foreach (vecs[i]) run_op(vecs[i]);

        // Abort a multiply mid-run; the discarded result must never appear.
        in_valid = 1'b1; mcand = 16'h1234; mplier = 16'h5678;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort product", product, 32'd0);
        saw_valid = 0;
        repeat (20) begin
            tick();
            if (out_valid) saw_valid++;
        end
        check("abort no late valid", 32'(saw_valid), 32'd0);
        begin
            vec_t v2;
            v2 = '{a: 16'd2, b: 16'd2, exp: 32'd4, hold: 0, name: "2x2 after abort"};
            run_op(v2);
        end

        // Random stream: producer and consumer run independently.
        sent = 0;
        received = 0;
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    logic [15:0] a;
                    logic [15:0] b;
                    int          wait_cnt;
                    logic        took;
                    repeat ($urandom_range(0, 3)) tick();
                    a = 16'($urandom);
                    b = 16'($urandom);
                    in_valid = 1'b1; mcand = a; mplier = b;
                    wait_cnt = 0;
                    took = 1'b0;
                    while (!took && wait_cnt < 200) begin
                        took = in_ready;
                        tick();
                        wait_cnt++;
                    end
                    in_valid = 1'b0;
                    if (took) begin
                        sb_q.push_back(32'(a) * 32'(b));
                        sent++;
                    end else begin
                        check("stream accept timeout", 32'(wait_cnt), 32'd0);
                    end
                end
            end
            begin
                int cyc;
                cyc = 0;
                while (received < 1000 && cyc < 60000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if (in_ready && out_valid) begin
                        check("stream ready/valid overlap", 32'd1, 32'd0);
                    end
                    if (out_valid && out_ready) begin
                        if (sb_q.size() == 0) begin
                            check("stream duplicate product", product, 32'hDEADBEEF);
                        end else begin
                            check("stream product", product, sb_q.pop_front());
                        end
                        received++;
                    end
                    tick();
                    cyc++;
                end
                out_ready = 1'b0;
            end
        join
        check("stream sent", 32'(sent), 32'd1000);
        check("stream received", 32'(received), 32'd1000);
        check("stream leftover", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
